// File: rtl/mips_alu_bit_serial_seq.sv
// Bit-serial W-bit MIPS ALU: one combinational 1-bit slice is reused LSB first,
// with carry, bit index, result shift register and SLT resolution held here.
module mips_alu_1bit (
    input  logic       ai,
    input  logic       bi,
    input  logic       ci,
    input  logic       lessi,
    input  logic [2:0] alu_op,
    output logic       ri,
    output logic       ci_1
);
    logic bx;
    logic sum;

    always_comb begin
        bx   = bi ^ alu_op[2];
        sum  = ai ^ bx ^ ci;
        ci_1 = (ai & bx) | (ai & ci) | (bx & ci);
        case (alu_op[1:0])
            2'b00:   ri = ai & bx;
            2'b01:   ri = ai | bx;
            2'b10:   ri = sum;
            default: ri = lessi;
        endcase
    end
endmodule

module mips_alu_bit_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    logic [2:0]       slice_op;
    logic             s_ri;
    logic             s_co;
    logic             last_bit;
    logic             ovf_v;
    logic [WIDTH-1:0] fin_result;
    logic             fin_c;
    logic             fin_v;

    // SLT runs the slice as a subtract; the less-than bit is resolved at the MSB.
    assign slice_op = (op_q == 3'b111) ? 3'b110 : op_q;
    assign last_bit = (idx == LAST);

    mips_alu_1bit u_slice (
        .ai     (a_q[idx]),
        .bi     (b_q[idx]),
        .ci     (carry),
        .lessi  (1'b0),
        .alu_op (slice_op),
        .ri     (s_ri),
        .ci_1   (s_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Final value as seen at the MSB edge: carry is the carry into the MSB, s_co the final carry.
    always_comb begin
        fin_result            = res_sr;
        fin_result[WIDTH-1]   = s_ri;
        ovf_v                 = carry ^ s_co;
        fin_c                 = 1'b0;
        fin_v                 = 1'b0;
        case (op_q)
            3'b000, 3'b001: ;
            3'b010, 3'b110: begin
                fin_c = s_co;
                fin_v = ovf_v;
            end
            3'b111: begin
                fin_result    = '0;
                fin_result[0] = s_ri ^ ovf_v;
            end
            default: fin_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            res_sr    <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    carry  <= alu_op[2];
                    idx    <= '0;
                    res_sr <= '0;
                end
                RUN: begin
                    res_sr[idx] <= s_ri;
                    carry       <= s_co;
                    idx         <= last_bit ? '0 : idx + 1'b1;
                    if (last_bit) begin
                        result    <= fin_result;
                        zero      <= (fin_result == '0);
                        carry_out <= fin_c;
                        overflow  <= fin_v;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_bit_serial_seq.sv
// Directed bench for the bit-serial ALU at WIDTH=32.
module tb_mips_alu_bit_serial_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alu_op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, carry_out, overflow;
    logic [31:0] result;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] r_res;
    logic        r_z, r_c, r_v;
    int          r_lat;

    mips_alu_bit_serial_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0},
        '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0},
        '{3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
        '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1},
        '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0},
        '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0},
        '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0},
        '{3'b111, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0},
        '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0},
        '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0},
        '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b1, 1'b0, 1'b0},
        '{3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0}
    };

    // Issues one request, scrambles the inputs after acceptance, waits (bounded) for done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        a      = av;
        b      = bv;
        @(negedge clk);
        start  = 1'b0;
        alu_op = 3'b001;
        a      = 32'hDEADBEEF;
        b      = 32'h5A5A5A5A;
        r_lat  = 0;
        while (done !== 1'b1 && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
        end
        r_res = result;
        r_z   = zero;
        r_c   = carry_out;
        r_v   = overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, done, result, zero, carry_out, overflow} !== 37'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h z=%b c=%b v=%b, expected all 0",
                     busy, done, result, zero, carry_out, overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_add_overflow();
        @(negedge clk);
        start  = 1'b1;
        alu_op = 3'b010;
        a      = 32'h7FFFFFFF;
        b      = 32'h00000001;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL run_busy: got busy=%b done=%b expected busy=1 done=0", busy, done);
        else pass_cnt++;
        r_lat = 0;
        while (done !== 1'b1 && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
        end
        total_cnt++;
        if (r_lat !== 32) $display("FAIL add_latency: got %0d expected 32", r_lat);
        else pass_cnt++;
        total_cnt++;
        if ({result, zero, carry_out, overflow} !== {32'h80000000, 1'b0, 1'b0, 1'b1})
            $display("FAIL add_ovf: got %h z=%b c=%b v=%b expected 80000000 z=0 c=0 v=1",
                     result, zero, carry_out, overflow);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h80000000)
            $display("FAIL done_width: got done=%b busy=%b result=%h expected 0 0 80000000",
                     done, busy, result);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv);
            total_cnt++;
            if (r_lat !== 32) $display("FAIL vec%0d_latency: got %0d expected 32", i, r_lat);
            else pass_cnt++;
            total_cnt++;
            if ({r_res, r_z, r_c, r_v} !== {vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v})
                $display("FAIL vec%0d_op%b: got %h z=%b c=%b v=%b expected %h z=%b c=%b v=%b",
                         i, vecs[i].op, r_res, r_z, r_c, r_v,
                         vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extra;
        @(negedge clk);
        start  = 1'b1;
        alu_op = 3'b010;
        a      = 32'd3;
        b      = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        alu_op = 3'b110;
        a      = 32'd9;
        b      = 32'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat !== 32 || result !== 32'd7)
            $display("FAIL busy_first_done: got lat=%0d result=%h expected lat=32 result=00000007",
                     lat, result);
        else pass_cnt++;
        start  = 1'b1;
        alu_op = 3'b110;
        a      = 32'd9;
        b      = 32'd1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL busy_after_done: got busy=%b done=%b expected 0 0", busy, done);
        else pass_cnt++;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL busy_extra_done: got %0d pulses expected 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'd7) $display("FAIL busy_result_held: got %h expected 00000007", result);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        int extra;
        @(negedge clk);
        start  = 1'b1;
        alu_op = 3'b010;
        a      = 32'h12345678;
        b      = 32'h11111111;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b0)
            $display("FAIL midrun_reset: got busy=%b done=%b result=%h z=%b expected 0 0 00000000 0",
                     busy, done, result, zero);
        else pass_cnt++;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL midrun_no_done: got %0d pulses expected 0", extra);
        else pass_cnt++;
        run_op(3'b010, 32'd2, 32'd2);
        total_cnt++;
        if (r_lat !== 32 || r_res !== 32'd4 || r_z !== 1'b0)
            $display("FAIL after_reset_add: got lat=%0d result=%h z=%b expected 32 00000004 0",
                     r_lat, r_res, r_z);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_vectors();
        test_start_while_busy();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule
